imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller for the LC3 core: sequences the instruction-memory bus (PC, instrmem_rd, complete_instr, Instr_dout) and owns the fetch program counter. It buffers returned instructions in a 2-entry queue toward decode, and handles stalls from decode and branch/jump redirects from execute. It is the initiator side of the imem bus; the memory (or the imem responder agent) is the other end.

---
 rtl/imem_fetch_pkg.sv | 18 +
 rtl/imem_fetch_fifo.sv | 71 +++++++
 rtl/imem_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, queue entry layout
// and the default reset PC.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDiscard
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    localparam logic [15:0] DefaultPcReset = 16'h3000;

endpackage

// File: rtl/imem_fetch_fifo.sv
// Small shift-register FIFO of fetched instructions; entry 0 is always the head, so the
// head outputs come straight from flops.
module imem_fetch_fifo
    import imem_fetch_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  fetch_entry_t    push_data,
    input  logic            pop,
    input  logic            flush,
    output logic [CntW-1:0] count,
    output logic            head_valid,
    output fetch_entry_t    head
);

    fetch_entry_t    entries_q [Depth];
    fetch_entry_t    entries_d [Depth];
    logic [CntW-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    logic            do_pop, do_push;
    logic [CntW-1:0] wr_idx;

    assign do_pop  = pop & valid_q;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push & ((count_q < CntW'(Depth)) | do_pop);
    assign wr_idx  = count_q - CntW'(do_pop);

    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int unsigned i = 0; i + 1 < Depth; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
            end
            for (int unsigned i = 0; i < Depth; i++) begin
                if (do_push && (CntW'(i) == wr_idx)) begin
                    entries_d[i] = push_data;
                end
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
        end
    end

    assign count      = count_q;
    assign head_valid = valid_q;
    assign head       = entries_q[0];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: drives the single-outstanding imem read bus, owns the
// fetch PC, and queues returned instructions toward decode with redirect flushing.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [15:0] PC_RESET   = DefaultPcReset,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_enable,
    output logic [15:0] PC,
    output logic        instrmem_rd,
    input  logic        complete_instr,
    input  logic [15:0] Instr_dout,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    if (!(FIFO_DEPTH == 2 || FIFO_DEPTH == 4)) begin : gen_bad_depth
        $error("imem_fetch_ctrl: FIFO_DEPTH must be 2 or 4");
    end

    fetch_state_e    state_q, state_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [15:0]     pc_q, pc_d;
    logic            rd_q, rd_d;

    logic            push, pop_eff;
    logic [CntW-1:0] count, post_count;
    fetch_entry_t    push_entry, head;
    logic            head_valid;

    assign push       = (state_q == StReq) & complete_instr & ~redirect_valid;
    assign pop_eff    = head_valid & instr_ready;
    assign post_count = count + CntW'(push) - CntW'(pop_eff);
    assign push_entry = '{pc: fetch_pc_q, instr: Instr_dout};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        unique case (state_q)
            StIdle: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end else if (fetch_enable && (count < CntW'(FIFO_DEPTH))) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    // Without a completion the old request is still in flight.
                    if (complete_instr) begin
                        state_d = fetch_enable ? StReq : StIdle;
                    end else begin
                        state_d = StDiscard;
                    end
                end else if (complete_instr) begin
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    if (fetch_enable && (post_count < CntW'(FIFO_DEPTH))) begin
                        state_d = StReq;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDiscard: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end
                if (complete_instr) begin
                    state_d = fetch_enable ? StReq : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        rd_d = (state_d != StIdle);
        // The abandoned request keeps its address on the bus until memory answers.
        pc_d = (state_d == StDiscard) ? pc_q : fetch_pc_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= PC_RESET;
            pc_q       <= PC_RESET;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
        end
    end

    imem_fetch_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (instr_ready),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign PC          = pc_q;
    assign instrmem_rd = rd_q;
    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed timing scenarios plus a randomized run scored
// against the delivered-instruction stream.
module tb_imem_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic [15:0] PC;
    logic        instrmem_rd;
    logic        complete_instr;
    logic [15:0] Instr_dout;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int tests = 0;
    int fails = 0;

    imem_fetch_ctrl #(
        .PC_RESET   (16'h3000),
        .FIFO_DEPTH (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .PC             (PC),
        .instrmem_rd    (instrmem_rd),
        .complete_instr (complete_instr),
        .Instr_dout     (Instr_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clock = ~clock;

    // Memory contents: distinct per address so misrouted data is visible.
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        fetch_enable   = 1'b0;
        complete_instr = 1'b0;
        Instr_dout     = 16'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        instr_ready    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (PC !== 16'h3000 || instrmem_rd !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== 16'h0 || instr_pc !== 16'h0) begin
            fails++;
            $display("FAIL reset_values: got PC=%h rd=%b v=%b instr=%h ipc=%h expected 3000 0 0 0 0",
                     PC, instrmem_rd, instr_valid, instr, instr_pc);
        end
        fetch_enable = 1'b1;
        step();
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h3000) begin
            fails++;
            $display("FAIL first_req: got rd=%b PC=%h expected 1 3000", instrmem_rd, PC);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        do_reset();
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            a = 16'h3000 + 16'(i);
            complete_instr = 1'b1;
            Instr_dout     = mem_data(a);
            step();
            tests++;
            if (instr_valid !== 1'b1 || instr_pc !== a || instr !== mem_data(a) ||
                instrmem_rd !== 1'b1 || PC !== a + 16'd1) begin
                fails++;
                $display("FAIL b2b_%0d: got v=%b ipc=%h instr=%h rd=%b PC=%h expected 1 %h %h 1 %h",
                         i, instr_valid, instr_pc, instr, instrmem_rd, PC, a, mem_data(a),
                         a + 16'd1);
            end
        end
        complete_instr = 1'b0;
    endtask

    task automatic test_stall();
        int waited;
        do_reset();
        fetch_enable = 1'b1;
        instr_ready  = 1'b0;
        step();
        complete_instr = 1'b1;
        Instr_dout     = mem_data(16'h3000);
        step();
        tests++;
        if (instr_valid !== 1'b1 || instrmem_rd !== 1'b1 || PC !== 16'h3001) begin
            fails++;
            $display("FAIL stall_first: got v=%b rd=%b PC=%h expected 1 1 3001",
                     instr_valid, instrmem_rd, PC);
        end
        Instr_dout = mem_data(16'h3001);
        step();
        complete_instr = 1'b0;
        step();
        step();
        tests++;
        if (instrmem_rd !== 1'b0 || PC !== 16'h3002 || instr_pc !== 16'h3000) begin
            fails++;
            $display("FAIL stall_full: got rd=%b PC=%h ipc=%h expected 0 3002 3000",
                     instrmem_rd, PC, instr_pc);
        end
        instr_ready = 1'b1;
        step();
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h3001 || instr !== mem_data(16'h3001)) begin
            fails++;
            $display("FAIL stall_pop: got v=%b ipc=%h instr=%h expected 1 3001 %h",
                     instr_valid, instr_pc, instr, mem_data(16'h3001));
        end
        waited = 0;
        while (instrmem_rd !== 1'b1 && waited < 5) begin
            step();
            waited++;
        end
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h3002) begin
            fails++;
            $display("FAIL stall_resume: got rd=%b PC=%h expected 1 3002", instrmem_rd, PC);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            complete_instr = 1'b1;
            Instr_dout     = mem_data(16'h3000 + 16'(i));
            step();
        end
        complete_instr = 1'b0;
        instr_ready    = 1'b0;
        step();
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h3005 || instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL rw_pending: got rd=%b PC=%h v=%b expected 1 3005 1",
                     instrmem_rd, PC, instr_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 16'h4000;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h3005 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rw_discard: got rd=%b PC=%h v=%b expected 1 3005 0",
                     instrmem_rd, PC, instr_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (instrmem_rd !== 1'b1 || PC !== 16'h3005) begin
                fails++;
                $display("FAIL rw_hold_%0d: got rd=%b PC=%h expected 1 3005",
                         i, instrmem_rd, PC);
            end
        end
        complete_instr = 1'b1;
        Instr_dout     = mem_data(16'h3005);
        instr_ready    = 1'b1;
        step();
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h4000 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rw_restart: got rd=%b PC=%h v=%b expected 1 4000 0",
                     instrmem_rd, PC, instr_valid);
        end
        Instr_dout = mem_data(16'h4000);
        step();
        complete_instr = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h4000 || instr !== mem_data(16'h4000)) begin
            fails++;
            $display("FAIL rw_deliver: got v=%b ipc=%h instr=%h expected 1 4000 %h",
                     instr_valid, instr_pc, instr, mem_data(16'h4000));
        end
    endtask

    task automatic test_redirect_complete();
        do_reset();
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        step();
        complete_instr = 1'b1;
        Instr_dout     = mem_data(16'h3000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h5000;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || instrmem_rd !== 1'b1 || PC !== 16'h5000) begin
            fails++;
            $display("FAIL rc_same_cycle: got v=%b rd=%b PC=%h expected 0 1 5000",
                     instr_valid, instrmem_rd, PC);
        end
        Instr_dout = mem_data(16'h5000);
        step();
        complete_instr = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h5000) begin
            fails++;
            $display("FAIL rc_deliver: got v=%b ipc=%h expected 1 5000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (instrmem_rd !== 1'b0 || PC !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_idle: got rd=%b PC=%h expected 0 ffff", instrmem_rd, PC);
        end
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        step();
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_req: got rd=%b PC=%h expected 1 ffff", instrmem_rd, PC);
        end
        complete_instr = 1'b1;
        Instr_dout     = mem_data(16'hFFFF);
        step();
        tests++;
        if (instr_pc !== 16'hFFFF || instr_valid !== 1'b1 || PC !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_step: got ipc=%h v=%b PC=%h expected ffff 1 0000",
                     instr_pc, instr_valid, PC);
        end
        Instr_dout = mem_data(16'h0000);
        step();
        complete_instr = 1'b0;
        tests++;
        if (instr_pc !== 16'h0000 || instr !== mem_data(16'h0000)) begin
            fails++;
            $display("FAIL wrap_zero: got ipc=%h instr=%h expected 0000 %h",
                     instr_pc, instr, mem_data(16'h0000));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_enable = 1'b1;
        instr_ready  = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            complete_instr = 1'b1;
            Instr_dout     = mem_data(16'h3000 + 16'(i));
            step();
        end
        complete_instr = 1'b0;
        instr_ready    = 1'b0;
        step();
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h3010) begin
            fails++;
            $display("FAIL rm_pending: got rd=%b PC=%h expected 1 3010", instrmem_rd, PC);
        end
        reset = 1'b1;
        step();
        tests++;
        if (instrmem_rd !== 1'b0 || instr_valid !== 1'b0 || PC !== 16'h3000) begin
            fails++;
            $display("FAIL rm_cleared: got rd=%b v=%b PC=%h expected 0 0 3000",
                     instrmem_rd, instr_valid, PC);
        end
        reset = 1'b0;
        step();
        tests++;
        if (instrmem_rd !== 1'b1 || PC !== 16'h3000) begin
            fails++;
            $display("FAIL rm_restart: got rd=%b PC=%h expected 1 3000", instrmem_rd, PC);
        end
    endtask

    // Reference: decode must see consecutive addresses starting at the reset PC or at the
    // latest redirect target, each carrying that address's memory word.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] out_pc;
        logic        outstanding;
        logic        redir_prev;
        int          delivered;
        do_reset();
        exp_pc      = 16'h3000;
        out_pc      = 16'h0;
        outstanding = 1'b0;
        redir_prev  = 1'b0;
        delivered   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (outstanding) begin
                tests++;
                if (instrmem_rd !== 1'b1 || PC !== out_pc) begin
                    fails++;
                    $display("FAIL rnd_bus_stable @%0d: got rd=%b PC=%h expected 1 %h",
                             cyc, instrmem_rd, PC, out_pc);
                end
            end
            if (redir_prev) begin
                tests++;
                if (instr_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rnd_flush @%0d: got v=%b expected 0", cyc, instr_valid);
                end
            end
            fetch_enable   = ($urandom_range(0, 9) != 0);
            instr_ready    = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                                         : 16'($urandom);
            if (instrmem_rd) begin
                complete_instr = ($urandom_range(0, 2) == 0);
                Instr_dout     = mem_data(PC);
            end else begin
                complete_instr = ($urandom_range(0, 7) == 0);
                Instr_dout     = ~mem_data(PC);
            end
            if (instr_valid && instr_ready && !redirect_valid) begin
                tests++;
                if (instr_pc !== exp_pc || instr !== mem_data(exp_pc)) begin
                    fails++;
                    $display("FAIL rnd_deliver @%0d: got ipc=%h instr=%h expected %h %h",
                             cyc, instr_pc, instr, exp_pc, mem_data(exp_pc));
                end
                exp_pc = exp_pc + 16'd1;
                delivered++;
            end
            outstanding = instrmem_rd && !complete_instr;
            out_pc      = PC;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
            end
            redir_prev = redirect_valid;
            step();
        end
        redirect_valid = 1'b0;
        complete_instr = 1'b0;
        tests++;
        if (delivered < 150) begin
            fails++;
            $display("FAIL rnd_progress: got %0d deliveries expected at least 150", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect_wait();
        test_redirect_complete();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
